// File: rtl/fb_port_arbiter.sv
// Two-client round-robin arbiter for the shared frame-store port.
// Each grant is capped at MAX_BURST acked transfers so neither engine can starve the other.
//   state | meaning
//   IDLE  | no owner, memory side parked on client 0 with mem_req=0
//   OWN0  | client 0 owns the frame-store port
//   OWN1  | client 1 owns the frame-store port
module fb_port_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_req,
  output logic        c0_ack,
  input  logic [17:0] c0_addr,
  input  logic [3:0]  c0_nbyte,
  input  logic        c0_rnw,
  input  logic [31:0] c0_w_data,
  output logic [31:0] c0_r_data,
  input  logic        c1_req,
  output logic        c1_ack,
  input  logic [17:0] c1_addr,
  input  logic [3:0]  c1_nbyte,
  input  logic        c1_rnw,
  input  logic [31:0] c1_w_data,
  output logic [31:0] c1_r_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbyte,
  output logic        mem_rnw,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data,
  output logic [1:0]  gnt
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ptr;
  logic            w_ptr_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_own_req;
  logic            w_oth_req;
  logic            w_rel_a;
  logic            w_rel_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign gnt = {r_state == OWN1, r_state == OWN0};

  assign w_own_req = gnt[1] ? c1_req : c0_req;
  assign w_oth_req = gnt[1] ? c0_req : c1_req;
  assign w_rel_a   = !w_own_req && !mem_ack;
  assign w_rel_b   = mem_ack && (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (c0_req && c1_req) w_state_nxt = r_ptr ? OWN1 : OWN0;
        else if (c0_req)      w_state_nxt = OWN0;
        else if (c1_req)      w_state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (w_rel_a || w_rel_b) begin
          // pointer always passes to the other client, even if the owner re-enters alone
          w_ptr_nxt = (r_state == OWN0);
          w_cnt_nxt = '0;
          if (w_oth_req)                w_state_nxt = (r_state == OWN0) ? OWN1 : OWN0;
          else if (w_rel_b && w_own_req) w_state_nxt = r_state;
          else                          w_state_nxt = IDLE;
        end else if (mem_ack) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_req    = (gnt[0] & c0_req) | (gnt[1] & c1_req);
  assign mem_addr   = gnt[1] ? c1_addr   : c0_addr;
  assign mem_nbyte  = gnt[1] ? c1_nbyte  : c0_nbyte;
  assign mem_rnw    = gnt[1] ? c1_rnw    : c0_rnw;
  assign mem_w_data = gnt[1] ? c1_w_data : c0_w_data;

  assign c0_ack    = mem_ack & gnt[0];
  assign c1_ack    = mem_ack & gnt[1];
  assign c0_r_data = mem_r_data;
  assign c1_r_data = mem_r_data;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: instance 0 runs with MAX_BURST=4, instance 1 with MAX_BURST=1.
// Directed scenarios use constant expectations; the random run uses a grant/count/pointer model.
module tb_fb_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        req    [2][2];
  logic [17:0] addr   [2][2];
  logic [3:0]  nbyte  [2][2];
  logic        rnw    [2][2];
  logic [31:0] wdata  [2][2];
  logic        ack    [2][2];
  logic [31:0] rdata  [2][2];
  logic        mreq   [2];
  logic        mack   [2];
  logic [17:0] maddr  [2];
  logic [3:0]  mnbyte [2];
  logic        mrnw   [2];
  logic [31:0] mwdata [2];
  logic [31:0] mrdata [2];
  logic [1:0]  gnt    [2];

  int n_tests = 0;
  int n_fail  = 0;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      fb_port_arbiter #(.MAX_BURST(g == 0 ? 4 : 1)) u_dut (
        .clk(clk), .rst_n(rst_n[g]),
        .c0_req(req[g][0]), .c0_ack(ack[g][0]), .c0_addr(addr[g][0]), .c0_nbyte(nbyte[g][0]),
        .c0_rnw(rnw[g][0]), .c0_w_data(wdata[g][0]), .c0_r_data(rdata[g][0]),
        .c1_req(req[g][1]), .c1_ack(ack[g][1]), .c1_addr(addr[g][1]), .c1_nbyte(nbyte[g][1]),
        .c1_rnw(rnw[g][1]), .c1_w_data(wdata[g][1]), .c1_r_data(rdata[g][1]),
        .mem_req(mreq[g]), .mem_ack(mack[g]), .mem_addr(maddr[g]), .mem_nbyte(mnbyte[g]),
        .mem_rnw(mrnw[g]), .mem_w_data(mwdata[g]), .mem_r_data(mrdata[g]), .gnt(gnt[g])
      );
    end
  endgenerate

  task automatic set_idle(input int k);
    for (int n = 0; n < 2; n++) begin
      req[k][n] = 1'b0; addr[k][n] = '0; nbyte[k][n] = '0; rnw[k][n] = 1'b0; wdata[k][n] = '0;
    end
    mack[k] = 1'b0; mrdata[k] = '0;
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    set_idle(k);
    rst_n[k] = 1'b0;
    @(negedge clk);
    rst_n[k] = 1'b1;
  endtask

  task automatic test_reset(input int k);
    @(negedge clk);
    rst_n[k] = 1'b0;
    req[k][0] = 1'b1; req[k][1] = 1'b1;
    #1;
    n_tests++; if (gnt[k] !== 2'b00) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b want 00", k, gnt[k]); end
    n_tests++; if (mreq[k] !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req[%0d]: got %b want 0", k, mreq[k]); end
    @(negedge clk);
    n_tests++; if (gnt[k] !== 2'b00) begin n_fail++; $display("FAIL reset_hold_gnt[%0d]: got %b want 00", k, gnt[k]); end
    n_tests++; if (ack[k][0] !== 1'b0 || ack[k][1] !== 1'b0) begin n_fail++; $display("FAIL reset_acks[%0d]: got %b%b want 00", k, ack[k][1], ack[k][0]); end
    set_idle(k);
    rst_n[k] = 1'b1;
  endtask

  task automatic test_first_request();
    do_reset(0);
    @(negedge clk);
    req[0][0] = 1'b1; addr[0][0] = 18'h00123;
    #1;
    n_tests++; if (mreq[0] !== 1'b0) begin n_fail++; $display("FAIL first_idle_req: got %b want 0", mreq[0]); end
    @(negedge clk); #1;
    n_tests++; if (mreq[0] !== 1'b1) begin n_fail++; $display("FAIL first_mem_req: got %b want 1", mreq[0]); end
    n_tests++; if (maddr[0] !== 18'h00123) begin n_fail++; $display("FAIL first_addr: got %h want 00123", maddr[0]); end
    n_tests++; if (gnt[0] !== 2'b01) begin n_fail++; $display("FAIL first_gnt: got %b want 01", gnt[0]); end
    mack[0] = 1'b1; #1;
    n_tests++; if (ack[0][0] !== 1'b1) begin n_fail++; $display("FAIL first_c0_ack: got %b want 1", ack[0][0]); end
    n_tests++; if (ack[0][1] !== 1'b0) begin n_fail++; $display("FAIL first_c1_ack: got %b want 0", ack[0][1]); end
    @(negedge clk);
    req[0][0] = 1'b0; mack[0] = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (gnt[0] !== 2'b00) begin n_fail++; $display("FAIL first_release: got %b want 00", gnt[0]); end
  endtask

  task automatic test_back_to_back();
    int owner;
    do_reset(0);
    @(negedge clk);
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      owner = (i / 4) % 2;
      mack[0] = 1'b1;
      #1;
      n_tests++; if (mreq[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_mem_req cyc%0d: got %b want 1", i, mreq[0]); end
      n_tests++; if (gnt[0] !== (owner == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_gnt cyc%0d: got %b want owner %0d", i, gnt[0], owner); end
      n_tests++; if (ack[0][0] !== (owner == 0)) begin n_fail++; $display("FAIL b2b_c0_ack cyc%0d: got %b want %b", i, ack[0][0], owner == 0); end
      n_tests++; if (ack[0][1] !== (owner == 1)) begin n_fail++; $display("FAIL b2b_c1_ack cyc%0d: got %b want %b", i, ack[0][1], owner == 1); end
    end
  endtask

  task automatic test_release_pointer();
    do_reset(0);
    @(negedge clk);
    req[0][1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mack[0] = 1'b1; #1;
      n_tests++; if (gnt[0] !== 2'b10 || ack[0][1] !== 1'b1) begin n_fail++; $display("FAIL rel_c1_burst cyc%0d: got gnt %b ack %b want 10/1", i, gnt[0], ack[0][1]); end
    end
    @(negedge clk);
    req[0][1] = 1'b0; mack[0] = 1'b0; #1;
    n_tests++; if (gnt[0] !== 2'b10 || mreq[0] !== 1'b0) begin n_fail++; $display("FAIL rel_drop_cycle: got gnt %b req %b want 10/0", gnt[0], mreq[0]); end
    @(negedge clk);
    req[0][0] = 1'b1; req[0][1] = 1'b1; #1;
    n_tests++; if (gnt[0] !== 2'b00) begin n_fail++; $display("FAIL rel_idle: got %b want 00", gnt[0]); end
    @(negedge clk); #1;
    n_tests++; if (gnt[0] !== 2'b01) begin n_fail++; $display("FAIL rel_ptr_to_c0: got %b want 01", gnt[0]); end
    do_reset(0);
    @(negedge clk);
    req[0][0] = 1'b1;
    @(negedge clk);
    mack[0] = 1'b1; #1;
    n_tests++; if (ack[0][0] !== 1'b1) begin n_fail++; $display("FAIL rel_c0_ack: got %b want 1", ack[0][0]); end
    @(negedge clk);
    req[0][0] = 1'b0; mack[0] = 1'b0;
    @(negedge clk);
    req[0][0] = 1'b1; req[0][1] = 1'b1; #1;
    n_tests++; if (gnt[0] !== 2'b00) begin n_fail++; $display("FAIL rel_idle2: got %b want 00", gnt[0]); end
    @(negedge clk); #1;
    n_tests++; if (gnt[0] !== 2'b10) begin n_fail++; $display("FAIL rel_ptr_to_c1: got %b want 10", gnt[0]); end
  endtask

  task automatic test_write_read();
    do_reset(0);
    @(negedge clk);
    addr[0][0] = 18'h3FFFF; rnw[0][0] = 1'b1; nbyte[0][0] = 4'b0000; wdata[0][0] = 32'h1234_5678;
    req[0][1] = 1'b1; addr[0][1] = 18'h00ABC; rnw[0][1] = 1'b0; nbyte[0][1] = 4'b1101; wdata[0][1] = 32'hDEADBEEF;
    #1;
    n_tests++; if (maddr[0] !== 18'h3FFFF || mreq[0] !== 1'b0) begin n_fail++; $display("FAIL wr_idle_park: got addr %h req %b want 3ffff/0", maddr[0], mreq[0]); end
    @(negedge clk); #1;
    n_tests++; if (gnt[0] !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b want 10", gnt[0]); end
    n_tests++; if (mrnw[0] !== 1'b0) begin n_fail++; $display("FAIL wr_rnw: got %b want 0", mrnw[0]); end
    n_tests++; if (mnbyte[0] !== 4'b1101) begin n_fail++; $display("FAIL wr_nbyte: got %b want 1101", mnbyte[0]); end
    n_tests++; if (mwdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", mwdata[0]); end
    n_tests++; if (maddr[0] !== 18'h00ABC) begin n_fail++; $display("FAIL wr_addr: got %h want 00abc", maddr[0]); end
    mack[0] = 1'b1; #1;
    n_tests++; if (ack[0][1] !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", ack[0][1]); end
    @(negedge clk);
    rnw[0][1] = 1'b1; mrdata[0] = 32'h0000_00A5; mack[0] = 1'b1; #1;
    n_tests++; if (mrnw[0] !== 1'b1) begin n_fail++; $display("FAIL rd_rnw: got %b want 1", mrnw[0]); end
    n_tests++; if (rdata[0][1] !== 32'h0000_00A5) begin n_fail++; $display("FAIL rd_data: got %h want 000000a5", rdata[0][1]); end
    n_tests++; if (ack[0][1] !== 1'b1 || ack[0][0] !== 1'b0) begin n_fail++; $display("FAIL rd_acks: got c1 %b c0 %b want 1/0", ack[0][1], ack[0][0]); end
  endtask

  task automatic test_burst_one();
    do_reset(1);
    @(negedge clk);
    req[1][0] = 1'b1; addr[1][0] = 18'h2A5A5; #1;
    n_tests++; if (gnt[1] !== 2'b00) begin n_fail++; $display("FAIL b1_idle: got %b want 00", gnt[1]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mack[1] = 1'b1; #1;
      n_tests++; if (gnt[1] !== 2'b01 || mreq[1] !== 1'b1) begin n_fail++; $display("FAIL b1_grant cyc%0d: got gnt %b req %b want 01/1", i, gnt[1], mreq[1]); end
      n_tests++; if (ack[1][0] !== 1'b1) begin n_fail++; $display("FAIL b1_ack cyc%0d: got %b want 1", i, ack[1][0]); end
    end
    @(negedge clk);
    set_idle(1);
  endtask

  task automatic test_async_reset();
    do_reset(0);
    @(negedge clk);
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mack[0] = 1'b1;
    end
    @(negedge clk);
    mack[0] = 1'b0; #1;
    n_tests++; if (gnt[0] !== 2'b10 || mreq[0] !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got gnt %b req %b want 10/1", gnt[0], mreq[0]); end
    #1 rst_n[0] = 1'b0; #1;
    n_tests++; if (mreq[0] !== 1'b0) begin n_fail++; $display("FAIL ar_mem_req: got %b want 0", mreq[0]); end
    n_tests++; if (gnt[0] !== 2'b00) begin n_fail++; $display("FAIL ar_gnt: got %b want 00", gnt[0]); end
    @(negedge clk);
    rst_n[0] = 1'b1; #1;
    n_tests++; if (gnt[0] !== 2'b00) begin n_fail++; $display("FAIL ar_idle: got %b want 00", gnt[0]); end
    @(negedge clk); #1;
    n_tests++; if (gnt[0] !== 2'b01) begin n_fail++; $display("FAIL ar_c0_first: got %b want 01", gnt[0]); end
  endtask

  // Model: owner (-1 none), acks this grant, and which client wins the next tie.
  task automatic test_random(input int k, input int mb, input int ncyc);
    int   own, cnt, ptr, oth, sel;
    bit   ackd [2];
    bit   hit, rel;
    logic exp_mreq;
    logic [1:0] exp_gnt;
    own = -1; cnt = 0; ptr = 0; ackd[0] = 1'b0; ackd[1] = 1'b0;
    do_reset(k);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!req[k][n] || ackd[n]) begin
          req[k][n]   = ($urandom % 3) != 0;
          addr[k][n]  = 18'($urandom);
          nbyte[k][n] = 4'($urandom);
          rnw[k][n]   = 1'($urandom);
          wdata[k][n] = $urandom;
        end
      end
      exp_mreq  = (own >= 0) ? req[k][own] : 1'b0;
      mack[k]   = exp_mreq && (($urandom % 4) != 0);
      mrdata[k] = $urandom;
      exp_gnt   = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      sel       = (own == 1) ? 1 : 0;
      #1;
      n_tests++; if (gnt[k] !== exp_gnt) begin n_fail++; $display("FAIL rnd%0d_gnt cyc%0d: got %b want %b", k, c, gnt[k], exp_gnt); end
      n_tests++; if (mreq[k] !== exp_mreq) begin n_fail++; $display("FAIL rnd%0d_mem_req cyc%0d: got %b want %b", k, c, mreq[k], exp_mreq); end
      n_tests++; if (maddr[k] !== addr[k][sel] || mnbyte[k] !== nbyte[k][sel] || mrnw[k] !== rnw[k][sel] || mwdata[k] !== wdata[k][sel]) begin
        n_fail++; $display("FAIL rnd%0d_mux cyc%0d: got %h/%b/%b/%h want client %0d", k, c, maddr[k], mnbyte[k], mrnw[k], mwdata[k], sel);
      end
      n_tests++; if (ack[k][0] !== (mack[k] && own == 0) || ack[k][1] !== (mack[k] && own == 1)) begin
        n_fail++; $display("FAIL rnd%0d_acks cyc%0d: got %b%b want owner %0d ack %b", k, c, ack[k][1], ack[k][0], own, mack[k]);
      end
      if (mack[k]) begin
        n_tests++; if (rdata[k][sel] !== mrdata[k]) begin n_fail++; $display("FAIL rnd%0d_rdata cyc%0d: got %h want %h", k, c, rdata[k][sel], mrdata[k]); end
      end
      ackd[0] = mack[k] && own == 0;
      ackd[1] = mack[k] && own == 1;
      if (own < 0) begin
        if (req[k][0] && req[k][1]) own = ptr;
        else if (req[k][0])         own = 0;
        else if (req[k][1])         own = 1;
        cnt = 0;
      end else begin
        oth = 1 - own;
        hit = mack[k] && (cnt == mb - 1);
        rel = hit || (!req[k][own] && !mack[k]);
        if (rel) begin
          ptr = oth; cnt = 0;
          if (req[k][oth])               own = oth;
          else if (!(hit && req[k][own])) own = -1;
        end else if (mack[k]) begin
          cnt++;
        end
      end
    end
    @(negedge clk);
    set_idle(k);
  endtask

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    set_idle(0); set_idle(1);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    test_reset(0);
    test_reset(1);
    test_first_request();
    test_back_to_back();
    test_release_pointer();
    test_write_read();
    test_burst_one();
    test_async_reset();
    test_random(0, 4, 500);
    test_random(1, 1, 300);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Two-client arbiter sharing the single frame-store port (req/ack, 18-bit word address, byte-lane enables, rnw, 32-bit write/read data) between drawing engines, e.g. a dithering engine and a line/fill engine.
- Each client keeps its existing de_* handshake unchanged; the arbiter muxes the granted client onto the memory side and routes the ack back.
- Round-robin with a bounded burst length, so a long fill cannot starve the other engine.

Parameters:
- MAX_BURST, 16: acked transfers a client may complete per grant before it must re-arbitrate. Legal range 1..256.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- c0_req  in  1  client 0 transfer request, held until acked
- c0_ack  out  1  client 0 transfer done, one-cycle pulse
- c0_addr  in  18  client 0 word address
- c0_nbyte  in  4  client 0 byte-lane disables, active-low enable as on de_nbyte
- c0_rnw  in  1  client 0 read(1)/write(0)
- c0_w_data  in  32  client 0 write data
- c0_r_data  out  32  client 0 read data
- c1_req, c1_ack, c1_addr, c1_nbyte, c1_rnw, c1_w_data, c1_r_data: as client 0, for client 1
- mem_req  out  1  to frame store
- mem_ack  in  1  from frame store, one-cycle pulse, only while mem_req=1
- mem_addr  out  18
- mem_nbyte  out  4
- mem_rnw  out  1
- mem_w_data  out  32
- mem_r_data  in  32
- gnt  out  2  one-hot current owner; 00 = none

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, gnt=00, burst count 0, priority pointer favours client 0.
  - mem_req=0, c0_ack=c1_ack=0.
  - Reset mid-transfer abandons the transfer; clients must re-request.
- States IDLE, OWN0, OWN1. gnt is registered and equals {state==OWN1, state==OWN0}.
- IDLE:
  - If exactly one creq is high, go to that OWNn next edge.
  - If both are high, go to the client favoured by the pointer.
  - No requests: stay in IDLE.
- Memory-side mux (combinational on the gnt register):
  - mem_req = req of the granted client (0 in IDLE).
  - mem_addr/nbyte/rnw/w_data come from the granted client; in IDLE they are driven from client 0 with mem_req=0.
- Ack and read-data routing:
  - cn_ack = mem_ack & gnt[n]; the other client's ack stays 0.
  - c0_r_data and c1_r_data both = mem_r_data; valid only with their own ack.
- First request latency: 1 cycle from creq rising in IDLE to mem_req=1.
- Burst count:
  - Increments on each mem_ack in OWNn and clears on any grant change.
  - Width is ceil(log2(MAX_BURST+1)); it never wraps.
- Release from OWNn, evaluated at each edge:
  - (a) creq=0 with no ack this cycle, or
  - (b) mem_ack while count == MAX_BURST-1.
- On release:
  - Pointer moves to the other client.
  - Next state is OWN(other) if the other req is high.
  - Otherwise it is OWNn (count cleared) in case (b) when creq is still high.
  - Otherwise IDLE.
- Switching costs no idle cycle: the new owner's mem_req appears the cycle after release.
- Simultaneous events:
  - A client dropping req in the same cycle as its ack is legal; this is treated as (b) if the limit is hit, otherwise the next edge sees creq=0 and applies (a).
  - The non-granted client's req is ignored until release.
- Client 0 has no fixed priority beyond reset; steady contention strictly alternates bursts of MAX_BURST.
- Clients must hold addr/data stable while req is high and unacked; the arbiter does not register them.

Test Plan:
- Reset → gnt=00, mem_req=0, both acks 0. Then c0_req=1, addr=18'h00123 → cycle+1 mem_req=1, mem_addr=18'h00123, gnt=01. mem_ack → c0_ack pulse, c1_ack=0.
- MAX_BURST=4, c0_req and c1_req both held, mem_ack every cycle → acks in groups of 4: c0, c1, c0, …; gnt alternates 01/10 with no cycle where mem_req=0.
- c1 alone, 3 acks, then c1_req falls → gnt returns 00 the next cycle. A later simultaneous request from both clients goes to c0 (pointer moved past c1).
- Write path: c1 granted, c1_rnw=0, c1_nbyte=4'b1101, c1_w_data=32'hDEADBEEF → mem_rnw=0, mem_nbyte=4'b1101, mem_w_data=32'hDEADBEEF. Read: mem_r_data=32'h0000_00A5 with ack → c1_r_data=32'h0000_00A5 and c1_ack=1.
- MAX_BURST=1, c0 only, req held → one ack per grant, state re-enters OWN0 each time, gnt stays 01.
- rst_n low mid-burst with mem_req=1 → mem_req and gnt go 0 immediately (asynchronous). On release with both requesting, client 0 is granted first.
